// File: rtl/alu_issue_stage.sv
// Issue stage around the 32-bit ALU: registered operands, in-order result FIFO,
// valid/ready on both sides and a sticky overflow flag on the drain side.
module alu_issue_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  S_in,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        Zero_out,
  output logic        Overflow_out,
  output logic        Cout_out,
  output logic        ovf_sticky,
  input  logic        clr_sticky
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        c;
  } ent_t;

  logic          op_v;
  logic [2:0]    op_s;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [31:0]   alu_out;
  logic          alu_z;
  logic          alu_o;
  logic          alu_c;
  ent_t          mem [DEPTH];
  ent_t          head;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic [AW:0]   occ;
  logic          acc;
  logic          pop;

  ALU u_alu (
    .out      (alu_out),
    .Zero     (alu_z),
    .Overflow (alu_o),
    .Cout     (alu_c),
    .S        (op_s),
    .A        (op_a),
    .B        (op_b)
  );

  // occ counts every request accepted but not yet popped, so the FIFO
  // always has room when the operand register writes.
  assign occ       = cnt + {{AW{1'b0}}, op_v};
  assign in_ready  = occ < DEPTH_C;
  assign out_valid = cnt != '0;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head         = mem[rp];
  assign result       = head.res;
  assign Zero_out     = head.z;
  assign Overflow_out = head.o;
  assign Cout_out     = head.c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_v       <= 1'b0;
      op_s       <= '0;
      op_a       <= '0;
      op_b       <= '0;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      op_v <= acc;
      if (acc) begin
        op_s <= S_in;
        op_a <= A_in;
        op_b <= B_in;
      end
      if (op_v) begin
        mem[wp] <= '{res: alu_out, z: alu_z,
                     o: alu_o, c: alu_c};
        wp      <= wp + 1'b1;
      end
      if (pop)
        rp <= rp + 1'b1;
      unique case ({op_v, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (pop && head.o)
        ovf_sticky <= 1'b1;
      else if (clr_sticky)
        ovf_sticky <= 1'b0;
    end
  end
endmodule

module ALU (
  output logic [31:0] out,
  output logic        Zero,
  output logic        Overflow,
  output logic        Cout,
  input  logic [2:0]  S,
  input  logic [31:0] A,
  input  logic [31:0] B
);
  logic        sub;
  logic [31:0] bx;
  logic [32:0] sum;

  // Shared adder: SUB is A + ~B + 1, so Cout means "no borrow".
  always_comb begin
    sub      = (S == 3'b001);
    bx       = sub ? ~B : B;
    sum      = {1'b0, A} + {1'b0, bx} + {32'd0, sub};
    out      = '0;
    Overflow = 1'b0;
    Cout     = 1'b0;
    unique case (S)
      3'b000, 3'b001: begin
        out      = sum[31:0];
        Cout     = sum[32];
        Overflow = (A[31] == bx[31]) && (sum[31] != A[31]);
      end
      3'b010: out = A & B;
      3'b011: out = A | B;
      3'b100: out = A ^ B;
      3'b101: out = ~(A | B);
      3'b110: out = {31'd0, $signed(A) < $signed(B)};
      3'b111: out = A << B[4:0];
      default: out = '0;
    endcase
    Zero = (out == '0);
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Random and directed bench for alu_issue_stage against a queue-based
// transaction model of outstanding requests.
module tb_alu_issue_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  S_in;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        Zero_out;
  logic        Overflow_out;
  logic        Cout_out;
  logic        ovf_sticky;
  logic        clr_sticky;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .S_in         (S_in),
    .A_in         (A_in),
    .B_in         (B_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .Zero_out     (Zero_out),
    .Overflow_out (Overflow_out),
    .Cout_out     (Cout_out),
    .ovf_sticky   (ovf_sticky),
    .clr_sticky   (clr_sticky)
  );

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        c;
    int          t;
  } ent_t;

  typedef struct {
    logic [2:0]  s;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  ent_t mq[$];
  req_t rq[$];
  int   cyc;
  bit   msticky;
  int   n_tests;
  int   n_fail;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%0h exp=%0h",
               tag, $time, got, exp);
    end
  endtask

  function automatic ent_t ref_alu(input logic [2:0] s,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    ent_t e;
    logic [32:0] w;
    e.o = 1'b0;
    e.c = 1'b0;
    e.t = 0;
    case (s)
      3'd0: begin
        w   = {1'b0, a} + {1'b0, b};
        e.r = w[31:0];
        e.c = w[32];
        e.o = (a[31] == b[31]) && (e.r[31] != a[31]);
      end
      3'd1: begin
        e.r = a - b;
        e.c = (a >= b);
        e.o = (a[31] != b[31]) && (e.r[31] != a[31]);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: e.r = ~(a | b);
      3'd6: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.r = a << b[4:0];
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    msticky = 1'b0;
    cyc     = 0;
  endtask

  // Entry accepted on edge cyc+1 reaches the head after edge cyc+2.
  task automatic step(output bit acc);
    bit   ev;
    bit   pop;
    ent_t e;
    ev = (mq.size() > 0) && (cyc >= mq[0].t);
    check("in_ready", in_ready, mq.size() < DEPTH);
    check("out_valid", out_valid, ev);
    check("ovf_sticky", ovf_sticky, msticky);
    if (ev) begin
      check("result", result, mq[0].r);
      check("flags", {Zero_out, Overflow_out, Cout_out},
            {mq[0].z, mq[0].o, mq[0].c});
    end
    pop = ev && out_ready;
    acc = in_valid && (mq.size() < DEPTH);
    if (pop) begin
      e = mq.pop_front();
      if (e.o)
        msticky = 1'b1;
      else if (clr_sticky)
        msticky = 1'b0;
    end else if (clr_sticky) begin
      msticky = 1'b0;
    end
    if (acc) begin
      e   = ref_alu(S_in, A_in, B_in);
      e.t = cyc + 2;
      mq.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit ordy, input bit clr);
    bit acc;
    in_valid   = v;
    S_in       = s;
    A_in       = a;
    B_in       = b;
    out_ready  = ordy;
    clr_sticky = clr;
    step(acc);
  endtask

  // mode 0: always ready, 1: random ready/clr, 2: stalled for 8 cycles
  task automatic run(input int mode, input int budget);
    bit acc;
    int n = 0;
    int held = 0;
    while ((rq.size() > 0 || mq.size() > 0) && n < budget) begin
      in_valid = rq.size() > 0;
      if (rq.size() > 0) begin
        S_in = rq[0].s;
        A_in = rq[0].a;
        B_in = rq[0].b;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (n >= 8);
      endcase
      clr_sticky = (mode == 1) && ($urandom_range(0, 7) == 0);
      step(acc);
      if (acc) begin
        void'(rq.pop_front());
        if (n < 8) held++;
      end
      n++;
    end
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    check("drained", (rq.size() == 0) && (mq.size() == 0), 1);
    if (mode == 2)
      check("bp_accepts", held, DEPTH);
  endtask

  task automatic add_req(input logic [2:0] s,
                         input logic [31:0] a,
                         input logic [31:0] b);
    req_t r;
    r.s = s;
    r.a = a;
    r.b = b;
    rq.push_back(r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog @%0t", $time);
    $fatal(1);
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    S_in       = '0;
    A_in       = '0;
    B_in       = '0;
    model_reset();
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sticky", ovf_sticky, 0);
    check("rst_result", result, 0);
    check("rst_flags", {Zero_out, Overflow_out, Cout_out}, 0);
    @(negedge clk);
    reset = 1'b0;

    add_req(3'd0, 32'd0, 32'd1);
    run(0, 20);

    add_req(3'd0, 32'hFFFF_FFFF, 32'd1);
    add_req(3'd0, 32'h7FFF_FFFF, 32'd1);
    run(0, 20);
    check("ovf_set", ovf_sticky, 1);

    drive(1, 3'd0, 32'h7FFF_FFFF, 32'd1, 0, 1);
    drive(0, 3'd0, 32'd0, 32'd0, 0, 0);
    drive(0, 3'd0, 32'd0, 32'd0, 1, 1);
    check("sticky_prio", ovf_sticky, 1);
    drive(0, 3'd0, 32'd0, 32'd0, 0, 1);
    check("sticky_clr", ovf_sticky, 0);

    for (int k = 0; k < 6; k++)
      add_req(3'd0, 32'(k), 32'd1);
    run(2, 60);

    for (int i = 0; i < 20; i++)
      add_req(3'd0, 32'(i), 32'(i));
    run(0, 80);

    for (int i = 0; i < 200; i++)
      add_req(3'($urandom_range(0, 7)), rnd32(), rnd32());
    run(1, 2000);

    drive(1, 3'd0, 32'h7FFF_FFFF, 32'd1, 1, 0);
    drive(0, 3'd0, 32'd0, 32'd0, 1, 0);
    drive(0, 3'd0, 32'd0, 32'd0, 1, 0);
    drive(1, 3'd0, 32'd3, 32'd4, 0, 0);
    drive(1, 3'd0, 32'd5, 32'd6, 0, 0);
    drive(0, 3'd0, 32'd0, 32'd0, 0, 0);
    check("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sticky", ovf_sticky, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    add_req(3'd0, 32'd5, 32'd6);
    run(0, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
